// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous clock-like input over a fixed gate
// window of clk cycles, range-checks each count and declares lock after
// LOCK_N consecutive in-range windows.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CW          = 16,
  parameter int LOCK_N      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  input  logic [CW-1:0] lo_lim,
  input  logic [CW-1:0] hi_lim,
  output logic [CW-1:0] count,
  output logic          count_valid,
  output logic          in_range,
  output logic          locked
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int NW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] G_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX    = '1;
  localparam logic [NW-1:0] GOOD_MAX = NW'(LOCK_N);

  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  logic          s1, s2, s3, edge_q;
  logic [GW-1:0] gcnt;
  logic [CW-1:0] acc, acc_sum;
  logic          term, sum_in_range;
  logic [NW-1:0] good, good_next, good_inc;
  lock_t         state, state_next;

  // Synchronizer plus delay stage; the edge pulse is registered so it is
  // glitch-free and lands three clk cycles after the input rises.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1     <= sig_in;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 & ~s3;
    end
  end

  // The terminal-cycle edge belongs to the closing window, so the reported
  // count is the accumulator plus the current edge, saturated.
  // NOTE: every signal driven here gets a value first, so no latch is inferred.
  always_comb begin
    acc_sum      = (edge_q && (acc != C_MAX)) ? acc + CW'(1) : acc;
    term         = en && (gcnt == G_LAST);
    sum_in_range = (lo_lim <= acc_sum) && (acc_sum <= hi_lim);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      gcnt <= '0;
      acc  <= '0;
    end else if (term) begin
      gcnt <= '0;
      acc  <= '0;
    end else begin
      gcnt <= gcnt + GW'(1);
      acc  <= acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
    end else begin
      count_valid <= term;
      if (term) begin
        count    <= acc_sum;
        in_range <= sum_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      good  <= '0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  // A bad window drops lock together with its strobe; a good one moves the
  // run length towards LOCK_N and locks when it gets there.
  always_comb begin
    state_next = state;
    good_next  = good;
    good_inc   = (good == GOOD_MAX) ? good : good + NW'(1);
    if (!en) begin
      state_next = UNLOCKED;
      good_next  = '0;
    end else if (term) begin
      if (sum_in_range) begin
        good_next = good_inc;
        unique case (state)
          UNLOCKED: if (good_inc == GOOD_MAX) state_next = LOCKED;
          LOCKED:   state_next = LOCKED;
          default:  state_next = UNLOCKED;
        endcase
      end else begin
        good_next  = '0;
        state_next = UNLOCKED;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: drives a generated sig_in and compares every
// window against a model that counts recorded rises per gate window.
module tb_clk_freq_meter;

  localparam int G      = 100;
  localparam int CW     = 4;
  localparam int LOCK_N = 4;
  localparam int CMAX   = 15;

  logic          clk = 1'b0;
  logic          rst, en, sig_in;
  logic [CW-1:0] lo_lim, hi_lim, count;
  logic          count_valid, in_range, locked;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int rises[$];
  int sig_period = 0;
  int ph = 0;
  int pulse_at = -100;
  int win_t = 0;
  int m_good = 0;

  clk_freq_meter #(.GATE_CYCLES(G), .CW(CW), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .lo_lim(lo_lim), .hi_lim(hi_lim),
    .count(count), .count_valid(count_valid),
    .in_range(in_range), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and update sig_in; a rise is recorded
  // with the index of the rising clk edge that first captures it.
  task automatic step();
    logic nv;
    @(negedge clk);
    if (sig_period == 0) begin
      nv = (cyc + 1 >= pulse_at) && (cyc + 1 < pulse_at + 4);
    end else begin
      if (ph >= sig_period) ph = 0;
      nv = (ph < sig_period / 2);
      ph++;
    end
    if (nv && !sig_in) rises.push_back(cyc + 1);
    sig_in = nv;
  endtask

  // Edges are sampled three clk edges after capture; the window whose strobe
  // shows after clk edge t holds samples t-G+1..t.
  function automatic int model_count(input int t);
    int n = 0;
    foreach (rises[i])
      if ((rises[i] + 3 >= t - G + 1) && (rises[i] + 3 <= t)) n++;
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic run_window(input string tag);
    int early = 0;
    int exp_cnt;
    int exp_inr;
    while (cyc < win_t) begin
      step();
      if (cyc < win_t && count_valid) early++;
    end
    exp_cnt = model_count(win_t);
    exp_inr = (int'(lo_lim) <= exp_cnt) && (exp_cnt <= int'(hi_lim));
    if (exp_inr != 0) m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
    else m_good = 0;
    check({tag, "_early"}, early, 0);
    check({tag, "_valid"}, int'(count_valid), 1);
    check({tag, "_count"}, int'(count), exp_cnt);
    check({tag, "_inrange"}, int'(in_range), exp_inr);
    check({tag, "_locked"}, int'(locked), int'(m_good == LOCK_N));
    win_t += G;
  endtask

  initial begin
    int last_cnt, last_inr, strobes, lk_cycles, changes;
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; lo_lim = 4'd9; hi_lim = 4'd11;
    repeat (3) step();
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(count_valid), 0);
    check("rst_inrange", int'(in_range), 0);
    check("rst_locked", int'(locked), 0);

    rst = 1'b0;
    sig_period = 10;
    repeat (30) step();
    en = 1'b1; win_t = cyc + G; m_good = 0;
    for (int k = 0; k < 5; k++) begin
      run_window("acq");
      check("acq_cnt10", int'(count), 10);
      check("acq_lock", int'(locked), int'(k >= LOCK_N - 1));
    end

    sig_period = 20;
    run_window("trans");
    run_window("slow");
    check("slow_cnt5", int'(count), 5);
    check("slow_unlock", int'(locked), 0);
    sig_period = 10;
    repeat (5) run_window("regain");
    check("regain_lock", int'(locked), 1);

    lo_lim = 4'd12; hi_lim = 4'd8;
    run_window("inv");
    check("inv_out", int'(in_range), 0);

    for (int k = 0; k < 8; k++) begin
      sig_period = int'($urandom_range(3, 24));
      lo_lim = 4'($urandom_range(0, 15));
      hi_lim = 4'($urandom_range(0, 15));
      run_window("rand");
    end

    lo_lim = 4'd14; hi_lim = 4'd15;
    sig_period = 4;
    run_window("sat_t");
    run_window("sat4");
    check("sat4_cnt", int'(count), 15);
    sig_period = 3;
    run_window("sat3");
    check("sat3_cnt", int'(count), 15);

    lo_lim = 4'd9; hi_lim = 4'd11; sig_period = 10;
    repeat (5) run_window("relock");
    check("pre_drop_lock", int'(locked), 1);

    repeat (50) step();
    en = 1'b0; m_good = 0;
    last_cnt = int'(count); last_inr = int'(in_range);
    strobes = 0; lk_cycles = 0; changes = 0;
    repeat (150) begin
      step();
      strobes += int'(count_valid);
      lk_cycles += int'(locked);
      if (int'(count) != last_cnt || int'(in_range) != last_inr) changes++;
    end
    check("endrop_strobes", strobes, 0);
    check("endrop_locked", lk_cycles, 0);
    check("endrop_hold", changes, 0);
    en = 1'b1; win_t = cyc + G;
    run_window("re_en");

    sig_period = 0;
    repeat (40) step();
    rst = 1'b1;
    step();
    check("mrst_count", int'(count), 0);
    check("mrst_valid", int'(count_valid), 0);
    check("mrst_inrange", int'(in_range), 0);
    check("mrst_locked", int'(locked), 0);
    rst = 1'b0; win_t = cyc + G; m_good = 0;
    sig_period = 10;
    run_window("post_rst");

    sig_period = 0;
    run_window("quiet");
    pulse_at = win_t - 3;
    run_window("bnd");
    check("bnd_cnt1", int'(count), 1);
    run_window("bnd_next");
    check("bnd_next_cnt0", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
